// File: rtl/wire_bus_master.sv
// Initiator for the internal wire-endpoint bus.
// Turns a command stream into wire-in/wire-out bus cycles.
module wire_bus_master #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        ti_clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_err,
    output logic [15:0] rsp_rdata,
    output logic        bus_wr,
    output logic        bus_rd,
    output logic        bus_update,
    output logic        bus_capture,
    output logic [7:0]  bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_READ,
        S_RESP
    } state_t;

    state_t        r_state;
    logic          r_cmd_ready;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [15:0]   r_rsp_rdata;
    logic          r_bus_wr;
    logic          r_bus_rd;
    logic          r_bus_update;
    logic          r_bus_capture;
    logic [7:0]    r_bus_addr;
    logic [15:0]   r_bus_wdata;
    logic [CW-1:0] r_cnt;

    logic w_accept;
    logic w_wr_ok;
    logic w_rd_ok;
    logic w_tmo;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_wr_ok  = (cmd_addr[7:5] == 3'b000);
    assign w_rd_ok  = (cmd_addr[7:5] == 3'b001);
    assign w_tmo    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= 16'h0;
            r_bus_wr      <= 1'b0;
            r_bus_rd      <= 1'b0;
            r_bus_update  <= 1'b0;
            r_bus_capture <= 1'b0;
            r_bus_addr    <= 8'h0;
            r_bus_wdata   <= 16'h0;
            r_cnt         <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_cnt       <= '0;
                        unique case (cmd_op)
                            2'b00: begin
                                if (w_wr_ok) begin
                                    r_bus_wr    <= 1'b1;
                                    r_bus_addr  <= cmd_addr;
                                    r_bus_wdata <= cmd_wdata;
                                    r_state     <= S_STROBE;
                                end else begin
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_err   <= 1'b1;
                                    r_rsp_rdata <= 16'h0;
                                    r_state     <= S_RESP;
                                end
                            end
                            2'b01: begin
                                r_bus_update <= 1'b1;
                                r_state      <= S_STROBE;
                            end
                            2'b10: begin
                                r_bus_capture <= 1'b1;
                                r_state       <= S_STROBE;
                            end
                            2'b11: begin
                                if (w_rd_ok) begin
                                    r_bus_rd   <= 1'b1;
                                    r_bus_addr <= cmd_addr;
                                    r_state    <= S_READ;
                                end else begin
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_err   <= 1'b1;
                                    r_rsp_rdata <= 16'h0;
                                    r_state     <= S_RESP;
                                end
                            end
                        endcase
                    end
                end
                S_STROBE: begin
                    r_bus_wr      <= 1'b0;
                    r_bus_update  <= 1'b0;
                    r_bus_capture <= 1'b0;
                    r_bus_addr    <= 8'h0;
                    r_bus_wdata   <= 16'h0;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_err     <= 1'b0;
                    r_rsp_rdata   <= 16'h0;
                    r_state       <= S_RESP;
                end
                S_READ: begin
                    if (bus_ack) begin
                        r_bus_rd    <= 1'b0;
                        r_bus_addr  <= 8'h0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= bus_rdata;
                        r_state     <= S_RESP;
                    end else if (w_tmo) begin
                        r_bus_rd    <= 1'b0;
                        r_bus_addr  <= 8'h0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 16'h0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= 16'h0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;
    assign bus_wr      = r_bus_wr;
    assign bus_rd      = r_bus_rd;
    assign bus_update  = r_bus_update;
    assign bus_capture = r_bus_capture;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_wire_bus_master.sv
// Directed bench for wire_bus_master with a response scoreboard
// and a one-endpoint wire-out model on the return bus.
module tb_wire_bus_master;

    logic        ti_clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic        bus_wr;
    logic        bus_rd;
    logic        bus_update;
    logic        bus_capture;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    logic        ack_en;
    logic [15:0] ep_data;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
    } rsp_t;

    rsp_t q[$];

    int total;
    int bad;
    int c_wr, c_up, c_cap, c_rd, c_ovl;

    wire_bus_master #(.TIMEOUT_CYCLES(15)) dut (
        .ti_clk     (ti_clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_update (bus_update),
        .bus_capture(bus_capture),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    assign bus_ack   = ack_en & bus_rd;
    assign bus_rdata = bus_ack ? ep_data : 16'h0;

    initial begin
        ti_clk = 1'b0;
        forever #5 ti_clk = ~ti_clk;
    end

    initial begin
        c_wr = 0; c_up = 0; c_cap = 0; c_rd = 0; c_ovl = 0;
    end

    // Strobe counters and overlap detector on the bus.
    always @(posedge ti_clk) begin
        if (bus_wr) c_wr <= c_wr + 1;
        if (bus_update) c_up <= c_up + 1;
        if (bus_capture) c_cap <= c_cap + 1;
        if (bus_rd) c_rd <= c_rd + 1;
        if ((int'(bus_wr) + int'(bus_update)
             + int'(bus_capture) + int'(bus_rd)) > 1)
            c_ovl <= c_ovl + 1;
    end

    task automatic tick();
        @(posedge ti_clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op,
                         input logic [7:0] a,
                         input logic [15:0] d,
                         input bit push,
                         input logic e,
                         input logic [15:0] r);
        rsp_t x;
        if (push) begin
            x.err   = e;
            x.rdata = r;
            q.push_back(x);
        end
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
    endtask

    task automatic send(input logic [1:0] op,
                        input logic [7:0] a,
                        input logic [15:0] d,
                        input bit push,
                        input logic e,
                        input logic [15:0] r);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        drive(op, a, d, push, e, r);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_t x;
        if (q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            x = q.pop_front();
            chk("rsp_err", rsp_err, x.err);
            chk("rsp_rdata", rsp_rdata, x.rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
        chk("ready_back", cmd_ready, 1);
    endtask

    task automatic get_rsp(input int exp_lat);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("rsp_latency", n, exp_lat);
        chk("rsp_valid", rsp_valid, 1);
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_wr, s_up, s_cap, s_rd;
        total = 0;
        bad   = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 8'h0;
        cmd_wdata = 16'h0;
        rsp_ready = 1'b0;
        ack_en    = 1'b0;
        ep_data   = 16'h0;

        tick();
        tick();
        chk("rst_ctl",
            {cmd_ready, rsp_valid, rsp_err, bus_wr,
             bus_rd, bus_update, bus_capture}, 0);
        chk("rst_data", {rsp_rdata, bus_addr, bus_wdata}, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", cmd_ready, 1);
        chk("no_rsp_after_rst", rsp_valid, 0);

        // Write then commit.
        s_wr = c_wr;
        s_up = c_up;
        send(2'b00, 8'h05, 16'hA5A5, 1, 1'b0, 16'h0);
        chk("wr_strobe", bus_wr, 1);
        chk("wr_addr", bus_addr, 8'h05);
        chk("wr_data", bus_wdata, 16'hA5A5);
        chk("wr_busy", cmd_ready, 0);
        get_rsp(1);
        chk("wr_count", c_wr - s_wr, 1);

        send(2'b01, 8'hFF, 16'h0, 1, 1'b0, 16'h0);
        chk("upd_strobe", bus_update, 1);
        get_rsp(1);
        chk("upd_count", c_up - s_up, 1);
        chk("upd_no_wr", c_wr - s_wr, 1);

        // Capture then acked read.
        s_cap = c_cap;
        send(2'b10, 8'h00, 16'h0, 1, 1'b0, 16'h0);
        chk("cap_strobe", bus_capture, 1);
        get_rsp(1);
        chk("cap_count", c_cap - s_cap, 1);

        ack_en  = 1'b1;
        ep_data = 16'h1234;
        s_rd    = c_rd;
        send(2'b11, 8'h21, 16'h0, 1, 1'b0, 16'h1234);
        chk("rd_req", bus_rd, 1);
        chk("rd_addr", bus_addr, 8'h21);
        get_rsp(1);
        chk("rd_cycles", c_rd - s_rd, 1);

        // Read without ack times out.
        ack_en  = 1'b0;
        ep_data = 16'hFFFF;
        s_rd    = c_rd;
        send(2'b11, 8'h22, 16'h0, 1, 1'b1, 16'h0);
        chk("tmo_req", bus_rd, 1);
        get_rsp(15);
        chk("tmo_cycles", c_rd - s_rd, 15);

        // Range errors.
        s_wr = c_wr;
        s_rd = c_rd;
        send(2'b00, 8'h20, 16'h1111, 1, 1'b1, 16'h0);
        chk("rng_wr_nobus", {bus_wr, bus_rd}, 0);
        get_rsp(0);
        send(2'b11, 8'h03, 16'h0, 1, 1'b1, 16'h0);
        chk("rng_rd_nobus", {bus_wr, bus_rd}, 0);
        get_rsp(0);
        chk("rng_wr_cnt", c_wr - s_wr, 0);
        chk("rng_rd_cnt", c_rd - s_rd, 0);

        // Back-pressure on the response.
        send(2'b00, 8'h1F, 16'h5A5A, 1, 1'b0, 16'h0);
        tick();
        ack_en  = 1'b1;
        ep_data = 16'hBEEF;
        drive(2'b11, 8'h24, 16'h0, 1, 1'b0, 16'hBEEF);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_err", rsp_err, 0);
            chk("hold_rdata", rsp_rdata, 16'h0);
            chk("hold_busy", cmd_ready, 0);
            chk("hold_nobus", bus_rd, 0);
            tick();
        end
        chk("hold_valid_end", rsp_valid, 1);
        consume();
        tick();
        cmd_valid = 1'b0;
        chk("next_acc_rd", bus_rd, 1);
        chk("next_acc_addr", bus_addr, 8'h24);
        get_rsp(1);

        // Reset in the middle of a read.
        ack_en = 1'b0;
        send(2'b11, 8'h23, 16'h0, 0, 1'b0, 16'h0);
        tick();
        tick();
        chk("pre_rst_rd", bus_rd, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl",
            {cmd_ready, rsp_valid, rsp_err, bus_wr,
             bus_rd, bus_update, bus_capture}, 0);
        chk("mid_rst_data", {rsp_rdata, bus_addr, bus_wdata}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", cmd_ready, 1);
        for (int i = 0; i < 20; i++) begin
            chk("post_rst_norsp", {rsp_valid, bus_rd}, 0);
            tick();
        end

        chk("sb_drained", q.size(), 0);
        chk("no_overlap", c_ovl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
